kernel_kcore_hls_deadlock_sched: RTL and testbench
==================================================

KERNEL_KCORE_HLS_DEADLOCK_SCHED -- requirements
Module: kernel_kcore_hls_deadlock_sched

Interface
REQ-001 The block SHALL have parameter PROC_NUM, default 4, meaning the number of monitored processes (2..16).
REQ-002 The block SHALL have parameter CONFIRM_CYC, default 4, meaning the consecutive cycles a candidate's detect must hold before a trace starts (1..255).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 64, meaning the maximum number of TRACE cycles before an abort (2..65535).
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port dl_detect_vec, input, PROC_NUM, where bit p is the dl_detect_out of the detect unit of process p.
REQ-007 The block SHALL have port token_ret_vec, input, PROC_NUM, where bit p is the OR of token_in_vec at process p.
REQ-008 The block SHALL have port report_ack, input, 1, host acknowledge of a deadlock report.
REQ-009 The block SHALL have port origin_vec, output, PROC_NUM, a one-hot origin strobe to the detect units.
REQ-010 The block SHALL have port dl_detect_in, output, 1, broadcast to all units meaning an investigation is active.
REQ-011 The block SHALL have port token_clear, output, 1, broadcast token flush.
REQ-012 The block SHALL have port report_vld, output, 1, meaning a deadlock report is pending.
REQ-013 The block SHALL have port report_proc, output, PROC_NUM, the one-hot reporting process, valid while report_vld=1 and zero otherwise.
REQ-014 The block SHALL have port deadlock_flag, output, 1, sticky: set when any report is issued.
REQ-015 The block SHALL have port abort_cnt, output, 8, a saturating count of timed-out traces.

Function
REQ-016 The block SHALL implement an FSM with the states IDLE, CONFIRM, ORIGIN, TRACE, REPORT and CLEAR.
REQ-017 In IDLE, when dl_detect_vec is non-zero, the block SHALL latch a one-hot winner by round-robin starting at rr_ptr, clear conf_cnt, and go to CONFIRM.
REQ-018 In CONFIRM, if the winner's dl_detect_vec bit is 0, the block SHALL return to IDLE with no rr_ptr update and no output activity.
REQ-019 In CONFIRM, if the winner's bit is 1 and conf_cnt==CONFIRM_CYC-1, the block SHALL go to ORIGIN; otherwise it SHALL increment conf_cnt.
REQ-020 ORIGIN SHALL last exactly 1 cycle, with origin_vec=winner and dl_detect_in=1; the block SHALL clear the timer and go to TRACE.
REQ-021 In TRACE, the block SHALL hold dl_detect_in=1 and origin_vec=0, and increment the timer each cycle.
REQ-022 In TRACE, when (token_ret_vec & winner) and (dl_detect_vec & winner) are both non-zero, the block SHALL go to REPORT.
REQ-023 In TRACE, when the timer==TIMEOUT_CYC-1 without the REQ-022 condition, the block SHALL go to CLEAR and increment abort_cnt, saturating at 255.
REQ-024 If the REQ-022 condition and the timeout occur in the same cycle, the report SHALL win and abort_cnt SHALL be unchanged.
REQ-025 In REPORT, the block SHALL drive report_vld=1, report_proc=winner and dl_detect_in=1; deadlock_flag SHALL be set in the first REPORT cycle.
REQ-026 In REPORT, on report_ack=1 the block SHALL go to CLEAR.
REQ-027 report_ack while not in REPORT SHALL be ignored.
REQ-028 CLEAR SHALL last exactly 1 cycle with token_clear=1 and dl_detect_in=1; rr_ptr SHALL become winner index+1 mod PROC_NUM, and the block SHALL go to IDLE.
REQ-029 New requests SHALL be ignored outside IDLE.
REQ-030 Minimum latency SHALL be: detect rise -> origin strobe CONFIRM_CYC+1 cycles.
REQ-031 All outputs SHALL be registered from state or winner, with no combinational input-to-output path.
REQ-032 dl_detect_in SHALL be 1 exactly in the ORIGIN, TRACE, REPORT and CLEAR states.

Reset
REQ-033 Reset assertion SHALL asynchronously force IDLE with all outputs 0, abort_cnt=0, deadlock_flag=0, rr_ptr=0, winner=0 and all counters 0; this SHALL hold mid-operation from any state.
REQ-034 After reset deassertion, the first grant SHALL follow the REQ-017 round-robin rule from rr_ptr=0.
REQ-035 deadlock_flag SHALL be cleared only by reset.

Verification
REQ-036 The bench SHALL cover: PROC_NUM=4, CONFIRM_CYC=4, dl_detect_vec=4'b0100 held, token_ret_vec bit 2 pulsed 10 cycles after origin -> origin_vec=4'b0100 5 cycles after detect rise, report_vld=1 with report_proc=4'b0100, ack -> token_clear for 1 cycle, deadlock_flag=1.
REQ-037 The bench SHALL cover: dl_detect_vec=4'b1010 from reset -> first winner 4'b0010; after CLEAR with the request still present -> next winner 4'b1000.
REQ-038 The bench SHALL cover: winner detect dropping in the 2nd CONFIRM cycle -> IDLE, origin_vec never asserted, rr_ptr unchanged.
REQ-039 The bench SHALL cover: TIMEOUT_CYC=8 with no token return -> CLEAR after 8 TRACE cycles, abort_cnt=1, report_vld never 1; 300 timeouts -> abort_cnt=255.
REQ-040 The bench SHALL cover: token return coinciding with the timeout cycle -> REPORT, abort_cnt unchanged.
REQ-041 The bench SHALL cover: reset asserted during REPORT -> report_vld, dl_detect_in and deadlock_flag 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/kernel_kcore_hls_deadlock_sched.sv
`default_nettype none
// ============================================================================
// Module      : kernel_kcore_hls_deadlock_sched
// Description : Round-robin deadlock investigation scheduler for HLS detect units
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_kcore_hls_deadlock_sched #(
    parameter int PROC_NUM    = 4,
    parameter int CONFIRM_CYC = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] token_ret_vec,
    input  logic                report_ack,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                dl_detect_in,
    output logic                token_clear,
    output logic                report_vld,
    output logic [PROC_NUM-1:0] report_proc,
    output logic                deadlock_flag,
    output logic [7:0]          abort_cnt
);

    localparam int                   c_idx_w     = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;
    localparam logic [PROC_NUM-1:0]  c_one       = {{(PROC_NUM-1){1'b0}}, 1'b1};
    localparam logic [7:0]           c_conf_last = 8'(CONFIRM_CYC - 1);
    localparam logic [15:0]          c_time_last = 16'(TIMEOUT_CYC - 1);
    localparam logic [c_idx_w-1:0]   c_idx_last  = c_idx_w'(PROC_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONFIRM = 3'd1,
        S_ORIGIN  = 3'd2,
        S_TRACE   = 3'd3,
        S_REPORT  = 3'd4,
        S_CLEAR   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_idx_w-1:0]    r_rr_ptr;
    logic [c_idx_w-1:0]    r_win_idx;
    logic [PROC_NUM-1:0]   r_winner;
    logic [7:0]            r_conf_cnt;
    logic [15:0]           r_timer;
    logic [c_idx_w-1:0]    w_grant_idx;
    logic [c_idx_w-1:0]    w_scan_idx;
    logic                  w_found;
    logic                  w_win_det;
    logic                  w_hit;

    // Round-robin scan: first requesting process at or after r_rr_ptr
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        for (int i = 0; i < PROC_NUM; i++) begin
            automatic int j = int'(r_rr_ptr) + i;
            if (j >= PROC_NUM) j = j - PROC_NUM;
            w_scan_idx = c_idx_w'(j);
            if (!w_found && dl_detect_vec[w_scan_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
    end

    assign w_win_det = |(dl_detect_vec & r_winner);
    assign w_hit     = w_win_det && (|(token_ret_vec & r_winner));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs decode only registered state and winner
    always_comb begin
        w_state_nxt  = r_state;
        origin_vec   = '0;
        dl_detect_in = 1'b0;
        token_clear  = 1'b0;
        report_vld   = 1'b0;
        report_proc  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_state_nxt = S_CONFIRM;
            end
            S_CONFIRM: begin
                if (!w_win_det)                     w_state_nxt = S_IDLE;
                else if (r_conf_cnt == c_conf_last) w_state_nxt = S_ORIGIN;
            end
            S_ORIGIN: begin
                origin_vec   = r_winner;
                dl_detect_in = 1'b1;
                w_state_nxt  = S_TRACE;
            end
            S_TRACE: begin
                dl_detect_in = 1'b1;
                if (w_hit)                       w_state_nxt = S_REPORT;
                else if (r_timer == c_time_last) w_state_nxt = S_CLEAR;
            end
            S_REPORT: begin
                dl_detect_in = 1'b1;
                report_vld   = 1'b1;
                report_proc  = r_winner;
                if (report_ack) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                dl_detect_in = 1'b1;
                token_clear  = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr      <= '0;
            r_win_idx     <= '0;
            r_winner      <= '0;
            r_conf_cnt    <= '0;
            r_timer       <= '0;
            abort_cnt     <= '0;
            deadlock_flag <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_winner   <= c_one << w_grant_idx;
                        r_win_idx  <= w_grant_idx;
                        r_conf_cnt <= '0;
                    end
                end
                S_CONFIRM: begin
                    if (w_win_det && (r_conf_cnt != c_conf_last)) r_conf_cnt <= r_conf_cnt + 8'd1;
                end
                S_ORIGIN: begin
                    r_timer <= '0;
                end
                S_TRACE: begin
                    // A token return in the timeout cycle still counts as a report
                    if (w_hit) begin
                        deadlock_flag <= 1'b1;
                    end else if (r_timer == c_time_last) begin
                        if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_CLEAR: begin
                    r_rr_ptr <= (r_win_idx == c_idx_last) ? '0 : r_win_idx + c_idx_w'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kernel_kcore_hls_deadlock_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_kcore_hls_deadlock_sched
// Description : Directed bench with a behavioural model; instance 0 uses
//               TIMEOUT_CYC=64, instance 1 uses TIMEOUT_CYC=8
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_kcore_hls_deadlock_sched;

    localparam int c_to0 = 64;
    localparam int c_to1 = 8;
    localparam int c_cc  = 4;
    localparam int P_IDLE = 0, P_CONF = 1, P_ORIG = 2, P_TRACE = 3, P_REP = 4, P_CLR = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] det [2];
    logic [3:0] tok [2];
    logic       ack [2];
    logic [3:0] origin_vec [2];
    logic [3:0] report_proc [2];
    logic       dl_in [2];
    logic       tclr [2];
    logic       rvld [2];
    logic       flag [2];
    logic [7:0] abort [2];

    int n_cmp = 0;
    int n_err = 0;
    int or_cnt [2] = '{0, 0};
    int rv_cnt [2] = '{0, 0};
    int clr_cnt [2] = '{0, 0};

    // Model state: phase, winner index, round-robin start, counter, aborts, flag
    int m_ph [2]    = '{0, 0};
    int m_win [2]   = '{0, 0};
    int m_rr [2]    = '{0, 0};
    int m_cnt [2]   = '{0, 0};
    int m_abort [2] = '{0, 0};
    bit m_flag [2]  = '{0, 0};

    always #5 clock = ~clock;

    kernel_kcore_hls_deadlock_sched #(.PROC_NUM(4), .CONFIRM_CYC(c_cc), .TIMEOUT_CYC(c_to0)) u_dut0 (
        .clock(clock), .reset(reset), .dl_detect_vec(det[0]), .token_ret_vec(tok[0]),
        .report_ack(ack[0]), .origin_vec(origin_vec[0]), .dl_detect_in(dl_in[0]),
        .token_clear(tclr[0]), .report_vld(rvld[0]), .report_proc(report_proc[0]),
        .deadlock_flag(flag[0]), .abort_cnt(abort[0]));

    kernel_kcore_hls_deadlock_sched #(.PROC_NUM(4), .CONFIRM_CYC(c_cc), .TIMEOUT_CYC(c_to1)) u_dut1 (
        .clock(clock), .reset(reset), .dl_detect_vec(det[1]), .token_ret_vec(tok[1]),
        .report_ack(ack[1]), .origin_vec(origin_vec[1]), .dl_detect_in(dl_in[1]),
        .token_clear(tclr[1]), .report_vld(rvld[1]), .report_proc(report_proc[1]),
        .deadlock_flag(flag[1]), .abort_cnt(abort[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int  to;
        bit  found;
        int  j;
        to = (k == 0) ? c_to0 : c_to1;
        case (m_ph[k])
            P_IDLE: begin
                found = 0;
                for (int i = 0; i < 4; i++) begin
                    j = (m_rr[k] + i) % 4;
                    if (!found && det[k][j]) begin
                        found = 1;
                        m_win[k] = j;
                    end
                end
                if (found) begin
                    m_cnt[k] = 0;
                    m_ph[k]  = P_CONF;
                end
            end
            P_CONF: begin
                if (!det[k][m_win[k]])        m_ph[k] = P_IDLE;
                else if (m_cnt[k] == c_cc - 1) m_ph[k] = P_ORIG;
                else                           m_cnt[k]++;
            end
            P_ORIG: begin
                m_cnt[k] = 0;
                m_ph[k]  = P_TRACE;
            end
            P_TRACE: begin
                if (tok[k][m_win[k]] && det[k][m_win[k]]) begin
                    m_ph[k]   = P_REP;
                    m_flag[k] = 1;
                end else if (m_cnt[k] == to - 1) begin
                    m_ph[k]    = P_CLR;
                    m_abort[k] = (m_abort[k] < 255) ? m_abort[k] + 1 : 255;
                end else begin
                    m_cnt[k]++;
                end
            end
            P_REP: if (ack[k]) m_ph[k] = P_CLR;
            default: begin
                m_rr[k] = (m_win[k] + 1) % 4;
                m_ph[k] = P_IDLE;
            end
        endcase
    endtask

    always @(posedge clock or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_ph[k] = P_IDLE; m_win[k] = 0; m_rr[k] = 0;
                m_cnt[k] = 0; m_abort[k] = 0; m_flag[k] = 0;
            end else begin
                model_step(k);
            end
        end
    end

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("origin_vec[%0d]", k), 32'(origin_vec[k]),
                (m_ph[k] == P_ORIG) ? 32'(1 << m_win[k]) : 32'd0);
            chk($sformatf("dl_detect_in[%0d]", k), 32'(dl_in[k]), 32'(m_ph[k] >= P_ORIG));
            chk($sformatf("token_clear[%0d]", k), 32'(tclr[k]), 32'(m_ph[k] == P_CLR));
            chk($sformatf("report_vld[%0d]", k), 32'(rvld[k]), 32'(m_ph[k] == P_REP));
            chk($sformatf("report_proc[%0d]", k), 32'(report_proc[k]),
                (m_ph[k] == P_REP) ? 32'(1 << m_win[k]) : 32'd0);
            chk($sformatf("deadlock_flag[%0d]", k), 32'(flag[k]), 32'(m_flag[k]));
            chk($sformatf("abort_cnt[%0d]", k), 32'(abort[k]), 32'(m_abort[k]));
            if (origin_vec[k] != 4'd0) or_cnt[k]++;
            if (rvld[k])               rv_cnt[k]++;
            if (tclr[k])               clr_cnt[k]++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_origin(input int k, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (origin_vec[k] == 4'd0 && n < 30);
        chk("origin_seen", 32'(origin_vec[k] != 4'd0), 32'd1);
    endtask

    initial begin
        int n;
        int s;
        int c0;
        int guard;
        for (int k = 0; k < 2; k++) begin
            det[k] = '0; tok[k] = '0; ack[k] = 1'b0;
        end
        #1 reset = 1'b1;
        tick();
        tick();
        chk("rst_origin", 32'(origin_vec[0]), 32'd0);
        chk("rst_dl_in", 32'(dl_in[0]), 32'd0);
        chk("rst_flag", 32'(flag[0]), 32'd0);
        chk("rst_abort", 32'(abort[1]), 32'd0);
        reset = 1'b0;
        tick();

        // Ack outside REPORT has no effect
        ack[0] = 1'b1; tick(); ack[0] = 1'b0; tick();
        chk("stray_ack_tclr", 32'(tclr[0]), 32'd0);

        // Single request, token returned 10 cycles after origin
        det[0] = 4'b0100;
        wait_origin(0, n);
        chk("a_latency", 32'(n), 32'd5);
        chk("a_origin", 32'(origin_vec[0]), 32'h4);
        repeat (10) tick();
        tok[0] = 4'b0100;
        tick();
        tok[0] = 4'b0000;
        chk("a_report_vld", 32'(rvld[0]), 32'd1);
        chk("a_report_proc", 32'(report_proc[0]), 32'h4);
        chk("a_flag", 32'(flag[0]), 32'd1);
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        det[0] = 4'b0000;
        chk("a_tclr_on", 32'(tclr[0]), 32'd1);
        tick();
        chk("a_tclr_off", 32'(tclr[0]), 32'd0);
        chk("a_flag_sticky", 32'(flag[0]), 32'd1);

        // Round-robin order from reset
        do_reset();
        det[0] = 4'b1010;
        tok[0] = 4'b0010;
        wait_origin(0, n);
        chk("b_first_winner", 32'(origin_vec[0]), 32'h2);
        tick();
        tick();
        chk("b_report_proc", 32'(report_proc[0]), 32'h2);
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        tok[0] = 4'b0000;
        wait_origin(0, n);
        chk("b_second_winner", 32'(origin_vec[0]), 32'h8);
        det[0] = 4'b0000;

        // Detect dropping in the second CONFIRM cycle
        do_reset();
        s = or_cnt[0];
        det[0] = 4'b0001;
        tick();
        tick();
        det[0] = 4'b0000;
        repeat (8) tick();
        chk("c_no_origin", 32'(or_cnt[0] - s), 32'd0);
        det[0] = 4'b0011;
        wait_origin(0, n);
        chk("c_rr_unchanged", 32'(origin_vec[0]), 32'h1);
        det[0] = 4'b0000;

        // Timeout with TIMEOUT_CYC=8, then saturation
        do_reset();
        s = rv_cnt[1];
        det[1] = 4'b0001;
        wait_origin(1, n);
        chk("d_latency", 32'(n), 32'd5);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tclr[1] && n < 30);
        chk("d_trace_len", 32'(n - 1), 32'd8);
        chk("d_abort1", 32'(abort[1]), 32'd1);
        chk("d_no_report", 32'(rv_cnt[1] - s), 32'd0);
        c0 = clr_cnt[1];
        guard = 0;
        while ((clr_cnt[1] - c0) < 300 && guard < 6000) begin
            tick();
            guard++;
        end
        chk("d_300_timeouts", 32'((clr_cnt[1] - c0) >= 300), 32'd1);
        chk("d_abort_sat", 32'(abort[1]), 32'd255);
        det[1] = 4'b0000;

        // Token return in the timeout cycle, then reset during REPORT
        do_reset();
        det[1] = 4'b0001;
        wait_origin(1, n);
        repeat (8) tick();
        tok[1] = 4'b0001;
        tick();
        tok[1] = 4'b0000;
        chk("e_report_wins", 32'(rvld[1]), 32'd1);
        chk("e_abort_same", 32'(abort[1]), 32'd0);
        chk("e_flag_set", 32'(flag[1]), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("e_rst_rvld", 32'(rvld[1]), 32'd0);
        chk("e_rst_dl_in", 32'(dl_in[1]), 32'd0);
        chk("e_rst_flag", 32'(flag[1]), 32'd0);
        det[1] = 4'b0000;
        tick();
        reset = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire
